ex_mem_resolve: RTL and testbench

- Execute-to-memory stage that directly consumes the ALU result, overflow, isNotEqual and isLessThan flags.
- Registers each instruction into the EX/MEM latch using a valid/ready handshake.
- Resolves bne/blt branches and issues a one-cycle fetch redirect.
- Squashes the wrong-path instructions that follow a taken branch.
- Rewrites overflowing add/addi/sub into an rstatus write.

---
 rtl/ex_pkg.sv | 60 ++++++
 rtl/branch_squash_ctrl.sv | 66 ++++++
 rtl/ex_mem_resolve.sv | 122 ++++++++++++
 tb/tb_ex_mem_resolve.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared types and constants for the execute-to-memory stage.
//   op_class_t : instruction class seen by EX/MEM
//   sq_state_t : branch squash controller state
//   ex_mem_t   : EX/MEM latch payload
//   status_code() / branch_target() : small datapath helpers
package ex_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 17;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ALU  = 3'd0,
    OP_ADD  = 3'd1,
    OP_ADDI = 3'd2,
    OP_SUB  = 3'd3,
    OP_BNE  = 3'd4,
    OP_BLT  = 3'd5,
    OP_LW   = 3'd6,
    OP_SW   = 3'd7
  } op_class_t;

  typedef enum logic {
    RUN    = 1'b0,
    SQUASH = 1'b1
  } sq_state_t;

  localparam logic [DATA_W-1:0] STAT_ADD  = 32'd1;
  localparam logic [DATA_W-1:0] STAT_ADDI = 32'd2;
  localparam logic [DATA_W-1:0] STAT_SUB  = 32'd3;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
    logic [OP_W-1:0]   op;
  } ex_mem_t;

  // Status code written to rstatus for an overflowing arithmetic op.
  function automatic logic [DATA_W-1:0] status_code(input op_class_t op);
    logic [DATA_W-1:0] code;
    code = '0;
    case (op)
      OP_ADD:  code = STAT_ADD;
      OP_ADDI: code = STAT_ADDI;
      OP_SUB:  code = STAT_SUB;
      default: code = '0;
    endcase
    return code;
  endfunction

  // Branch target: pc + 1 + sign-extended offset, wrapping at 32 bits.
  function automatic logic [DATA_W-1:0] branch_target(input logic [DATA_W-1:0] pc,
                                                      input logic [IMM_W-1:0]  imm);
    return pc + DATA_W'(1) + {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/branch_squash_ctrl.sv
// RUN/SQUASH controller: after a taken branch in RUN, kills the next
// SQUASH_SLOTS accepted instructions and emits a one-cycle redirect pulse.
//   clock, reset_n : clock, async active-low reset
//   accept_i       : an instruction is accepted this cycle
//   taken_i        : the accepted instruction is a taken branch
//   kill_o         : instruction accepted this cycle must be dropped
//   redirect_o     : registered redirect pulse, cycle after the taken accept
module branch_squash_ctrl
  import ex_pkg::*;
#(
  parameter int unsigned SQUASH_SLOTS = 2
) (
  input  logic clock,
  input  logic reset_n,
  input  logic accept_i,
  input  logic taken_i,
  output logic kill_o,
  output logic redirect_o
);

  sq_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             redirect_q, redirect_d;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      redirect_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      redirect_q <= redirect_d;
    end
  end

  // Next state; only accepted instructions consume squash slots.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    redirect_d = 1'b0;
    case (state_q)
      RUN: begin
        if (accept_i && taken_i) begin
          state_d    = SQUASH;
          cnt_d      = CNT_W'(SQUASH_SLOTS);
          redirect_d = 1'b1;
        end
      end
      SQUASH: begin
        if (accept_i) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = RUN;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign kill_o     = (state_q == SQUASH);
  assign redirect_o = redirect_q;

endmodule

// File: rtl/ex_mem_resolve.sv
// Execute-to-memory stage: latches ALU results into the EX/MEM register with
// a valid/ready handshake, resolves bne/blt, redirects fetch and squashes the
// wrong-path instructions behind a taken branch.
// Optional macro RSTATUS_EN: rewrites overflowing add/addi/sub into a write
// of a status code to register RSTATUS_REG.
//   clock, reset_n          : clock, async active-low reset
//   in_valid / in_ready     : upstream handshake
//   op_class, alu_result, alu_overflow, alu_ne, alu_lt, pc, imm, store_data, rd
//                           : instruction fields from EX
//   out_valid / out_ready   : downstream handshake
//   out_result, out_store_data, out_rd, out_op : EX/MEM latch contents
//   redirect, redirect_pc   : taken-branch fetch redirect
module ex_mem_resolve
  import ex_pkg::*;
#(
  parameter int unsigned SQUASH_SLOTS = 2
`ifdef RSTATUS_EN
  , parameter int unsigned RSTATUS_REG = 30
`endif
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op_class,
  input  logic [31:0] alu_result,
  input  logic        alu_overflow,
  input  logic        alu_ne,
  input  logic        alu_lt,
  input  logic [31:0] pc,
  input  logic [16:0] imm,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [31:0] out_store_data,
  output logic [4:0]  out_rd,
  output logic [2:0]  out_op,
  output logic        redirect,
  output logic [31:0] redirect_pc
);

  ex_mem_t           latch_q, latch_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] rpc_q, rpc_d;
  op_class_t         op_c;
  logic              accept_c;
  logic              taken_c;
  logic              kill_c;

  assign op_c     = op_class_t'(op_class);
  // Held low during reset so nothing is offered as accepted.
  assign in_ready = reset_n && (!valid_q || out_ready);
  assign accept_c = in_valid && in_ready;
  assign taken_c  = ((op_c == OP_BNE) && alu_ne) || ((op_c == OP_BLT) && alu_lt);

  branch_squash_ctrl #(
    .SQUASH_SLOTS(SQUASH_SLOTS)
  ) u_squash (
    .clock      (clock),
    .reset_n    (reset_n),
    .accept_i   (accept_c),
    .taken_i    (taken_c),
    .kill_o     (kill_c),
    .redirect_o (redirect)
  );

`ifndef RSTATUS_EN
  logic unused_ovf;
  assign unused_ovf = alu_overflow;
`endif

  // EX/MEM latch next-state; squashed instructions are consumed but invalid.
  always_comb begin
    valid_d = valid_q;
    latch_d = latch_q;
    rpc_d   = rpc_q;
    if (accept_c) begin
      valid_d            = !kill_c;
      latch_d.result     = alu_result;
      latch_d.store_data = store_data;
      latch_d.rd         = rd;
      latch_d.op         = op_class;
      if (op_c inside {OP_BNE, OP_BLT, OP_SW}) begin
        latch_d.rd = '0;
      end
`ifdef RSTATUS_EN
      if (alu_overflow && (op_c inside {OP_ADD, OP_ADDI, OP_SUB})) begin
        latch_d.rd     = REG_W'(RSTATUS_REG);
        latch_d.result = status_code(op_c);
      end
`endif
      if (taken_c && !kill_c) begin
        rpc_d = branch_target(pc, imm);
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // EX/MEM latch registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      latch_q <= '0;
      rpc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      latch_q <= latch_d;
      rpc_q   <= rpc_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = latch_q.result;
  assign out_store_data = latch_q.store_data;
  assign out_rd         = latch_q.rd;
  assign out_op         = latch_q.op;
  assign redirect_pc    = rpc_q;

endmodule

// File: tb/tb_ex_mem_resolve.sv
// Directed bench for ex_mem_resolve with a cycle-level reference model.
module tb_ex_mem_resolve;
  import ex_pkg::*;

  localparam int SLOTS = 2;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op_class = 3'd0;
  logic [31:0] alu_result = 32'd0;
  logic        alu_overflow = 1'b0;
  logic        alu_ne = 1'b0;
  logic        alu_lt = 1'b0;
  logic [31:0] pc = 32'd0;
  logic [16:0] imm = 17'd0;
  logic [31:0] store_data = 32'd0;
  logic [4:0]  rd = 5'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd;
  logic [2:0]  out_op;
  logic        redirect;
  logic [31:0] redirect_pc;

  ex_mem_resolve dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .op_class       (op_class),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow),
    .alu_ne         (alu_ne),
    .alu_lt         (alu_lt),
    .pc             (pc),
    .imm            (imm),
    .store_data     (store_data),
    .rd             (rd),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_result     (out_result),
    .out_store_data (out_store_data),
    .out_rd         (out_rd),
    .out_op         (out_op),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: latch contents plus number of squash slots still owed.
  logic        m_valid = 1'b0;
  logic [31:0] m_result = 32'd0;
  logic [31:0] m_store = 32'd0;
  logic [4:0]  m_rd = 5'd0;
  logic [2:0]  m_op = 3'd0;
  logic        m_redirect = 1'b0;
  logic [31:0] m_rpc = 32'd0;
  int          m_left = 0;

  always @(posedge clock or negedge reset_n) begin
    bit          acc;
    bit          killed;
    bit          taken;
    int          off;
    logic [4:0]  nrd;
    logic [31:0] nres;
    if (!reset_n) begin
      m_valid    <= 1'b0;
      m_result   <= 32'd0;
      m_store    <= 32'd0;
      m_rd       <= 5'd0;
      m_op       <= 3'd0;
      m_redirect <= 1'b0;
      m_rpc      <= 32'd0;
      m_left     <= 0;
    end else begin
      acc = in_valid && (!m_valid || out_ready);
      m_redirect <= 1'b0;
      if (acc) begin
        killed = (m_left > 0);
        taken  = (op_class == OP_BNE && alu_ne) || (op_class == OP_BLT && alu_lt);
        nrd  = (op_class == OP_BNE || op_class == OP_BLT || op_class == OP_SW) ? 5'd0 : rd;
        nres = alu_result;
`ifdef RSTATUS_EN
        if (alu_overflow) begin
          case (op_class)
            OP_ADD:  begin nrd = 5'd30; nres = 32'd1; end
            OP_ADDI: begin nrd = 5'd30; nres = 32'd2; end
            OP_SUB:  begin nrd = 5'd30; nres = 32'd3; end
            default: ;
          endcase
        end
`endif
        m_valid  <= !killed;
        m_result <= nres;
        m_store  <= store_data;
        m_rd     <= nrd;
        m_op     <= op_class;
        if (killed) begin
          m_left <= m_left - 1;
        end else if (taken) begin
          off = int'($signed(imm));
          m_left     <= SLOTS;
          m_redirect <= 1'b1;
          m_rpc      <= pc + 32'd1 + 32'(off);
        end
      end else if (out_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(reset_n && (!m_valid || out_ready)));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("redirect", 32'(redirect), 32'(m_redirect));
      if (m_valid || !reset_n) begin
        check("out_result", out_result, m_result);
        check("out_rd", 32'(out_rd), 32'(m_rd));
        check("out_op", 32'(out_op), 32'(m_op));
      end
      if ((m_valid && m_op == OP_SW) || !reset_n) begin
        check("out_store_data", out_store_data, m_store);
      end
      if (m_redirect || !reset_n) begin
        check("redirect_pc", redirect_pc, m_rpc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic put(input logic [2:0] op, input logic [31:0] res, input logic ovf,
                     input logic ne, input logic lt, input logic [31:0] p,
                     input logic [16:0] im, input logic [31:0] sd, input logic [4:0] r);
    in_valid     = 1'b1;
    op_class     = op;
    alu_result   = res;
    alu_overflow = ovf;
    alu_ne       = ne;
    alu_lt       = lt;
    pc           = p;
    imm          = im;
    store_data   = sd;
    rd           = r;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    #1 chk_en = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_redirect", 32'(redirect), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    step();
    step();
    reset_n = 1'b1;

    // Back-to-back ALU ops.
    put(OP_ALU, 32'h5, 1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd3);
    step();
    check("alu0_valid", 32'(out_valid), 32'd1);
    check("alu0_result", out_result, 32'h5);
    check("alu0_rd", 32'(out_rd), 32'd3);
    put(OP_ALU, 32'h7, 1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd4);
    step();
    check("alu1_result", out_result, 32'h7);
    check("alu1_rd", 32'(out_rd), 32'd4);

    // Downstream stall for three cycles, then drain+accept in one edge.
    out_ready = 1'b0;
    put(OP_ALU, 32'h9, 1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd6);
    #1 check("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_result", out_result, 32'h7);
      check("stall_rd", 32'(out_rd), 32'd4);
    end
    out_ready = 1'b1;
    step();
    check("release_result", out_result, 32'h9);
    check("release_rd", 32'(out_rd), 32'd6);

    // Taken bne: redirect to 0x10 + 1 - 4, then two squashed slots.
    put(OP_BNE, 32'hAB, 1'b0, 1'b1, 1'b0, 32'h10, 17'h1FFFC, 32'h0, 5'd7);
    step();
    check("bne_valid", 32'(out_valid), 32'd1);
    check("bne_rd", 32'(out_rd), 32'd0);
    check("bne_redirect", 32'(redirect), 32'd1);
    check("bne_redirect_pc", redirect_pc, 32'h0000_000D);
    put(OP_ALU, 32'h11, 1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd1);
    step();
    check("sq1_valid", 32'(out_valid), 32'd0);
    check("sq1_redirect", 32'(redirect), 32'd0);
    idle();
    step();
    put(OP_BNE, 32'h12, 1'b0, 1'b1, 1'b0, 32'h40, 17'h8, 32'h0, 5'd2);
    step();
    check("sq2_valid", 32'(out_valid), 32'd0);
    check("sq2_redirect", 32'(redirect), 32'd0);
    put(OP_ALU, 32'h13, 1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd3);
    step();
    check("post_sq_valid", 32'(out_valid), 32'd1);
    check("post_sq_result", out_result, 32'h13);
    check("post_sq_redirect", 32'(redirect), 32'd0);

    // Not-taken blt.
    put(OP_BLT, 32'h20, 1'b0, 1'b1, 1'b0, 32'h20, 17'h5, 32'h0, 5'd9);
    step();
    check("blt_nt_valid", 32'(out_valid), 32'd1);
    check("blt_nt_redirect", 32'(redirect), 32'd0);
    put(OP_ALU, 32'h21, 1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd9);
    step();
    check("blt_nt_next_valid", 32'(out_valid), 32'd1);
    check("blt_nt_next_result", out_result, 32'h21);

    // Overflow handling and memory ops.
    put(OP_SUB, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd5);
    step();
`ifdef RSTATUS_EN
    check("sub_ovf_rd", 32'(out_rd), 32'd30);
    check("sub_ovf_result", out_result, 32'd3);
`else
    check("sub_ovf_rd", 32'(out_rd), 32'd5);
    check("sub_ovf_result", out_result, 32'h8000_0000);
`endif
    put(OP_ADD, 32'h7FFF_FFFE, 1'b1, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd6);
    step();
    put(OP_ADDI, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd7);
    step();
    put(OP_LW, 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd8);
    step();
    check("lw_result", out_result, 32'h100);
    check("lw_rd", 32'(out_rd), 32'd8);
    put(OP_SW, 32'h104, 1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 32'hDEAD_BEEF, 5'd9);
    step();
    check("sw_rd", 32'(out_rd), 32'd0);
    check("sw_store", out_store_data, 32'hDEAD_BEEF);
    check("sw_addr", out_result, 32'h104);
    put(OP_ADD, 32'h55, 1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd10);
    step();
    check("add_result", out_result, 32'h55);
    idle();
    step();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Taken blt, then reset while squashing with a valid latch.
    put(OP_BLT, 32'h0, 1'b0, 1'b0, 1'b1, 32'h20, 17'h5, 32'h0, 5'd1);
    step();
    check("blt_t_redirect", 32'(redirect), 32'd1);
    check("blt_t_redirect_pc", redirect_pc, 32'h26);
    reset_n = 1'b0;
    idle();
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_redirect", 32'(redirect), 32'd0);
    check("midrst_redirect_pc", redirect_pc, 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    reset_n = 1'b1;
    put(OP_ALU, 32'h33, 1'b0, 1'b0, 1'b0, 32'h0, 17'h0, 32'h0, 5'd8);
    step();
    check("post_rst_valid", 32'(out_valid), 32'd1);
    check("post_rst_result", out_result, 32'h33);
    idle();
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
